// File: rtl/fifo_axis_reader.sv
// Drains a registered-output synchronous FIFO into an AXI-Stream master through a 2-entry skid buffer.
// Define AXIS_TLAST_EN to compile in FRAME_LEN-word framing on M_AXIS_TLAST; otherwise TLAST is tied low.
module fifo_axis_reader #(
    parameter int DATA_WIDTH = 16,
    parameter int FRAME_LEN  = 160
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    output logic                  FIFO_RD_EN,
    input  logic [DATA_WIDTH-1:0] FIFO_RD_DATA,
    input  logic                  FIFO_EMPTY,
    output logic [DATA_WIDTH-1:0] M_AXIS_TDATA,
    output logic                  M_AXIS_TVALID,
    input  logic                  M_AXIS_TREADY,
    output logic                  M_AXIS_TLAST
);

`ifdef AXIS_TLAST_EN
    localparam int EW = DATA_WIDTH + 1;
    localparam int CW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(FRAME_LEN - 1);
`else
    localparam int EW = DATA_WIDTH;
`endif

    logic [1:0]    count_q, count_d;
    logic          inflight_q, inflight_d;
    logic [EW-1:0] buf0_q, buf0_d;
    logic [EW-1:0] buf1_q, buf1_d;
    logic          pop_s;
    logic          cap_s;
    logic [2:0]    occ_s;
    logic [EW-1:0] new_entry_s;

    assign M_AXIS_TVALID = (count_q != 2'd0);
    assign M_AXIS_TDATA  = buf0_q[DATA_WIDTH-1:0];

`ifdef AXIS_TLAST_EN
    logic [CW-1:0] frame_cnt_q, frame_cnt_d;
    logic [CW-1:0] cap_idx_s;

    assign M_AXIS_TLAST = buf0_q[DATA_WIDTH];

    // Frame index advances per handshake; a captured word sits count_q slots behind the head.
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        cap_idx_s   = frame_cnt_q;
        if (pop_s) begin
            frame_cnt_d = (frame_cnt_q == LAST_IDX) ? {CW{1'b0}} : frame_cnt_q + CW'(1);
        end else begin
            frame_cnt_d = frame_cnt_q;
        end
        if (count_q != 2'd0) begin
            cap_idx_s = (frame_cnt_q == LAST_IDX) ? {CW{1'b0}} : frame_cnt_q + CW'(1);
        end else begin
            cap_idx_s = frame_cnt_q;
        end
        new_entry_s = {(cap_idx_s == LAST_IDX), FIFO_RD_DATA};
    end

    // Frame counter register.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            frame_cnt_q <= {CW{1'b0}};
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end
`else
    assign M_AXIS_TLAST = 1'b0;
    assign new_entry_s  = FIFO_RD_DATA;
`endif

    // Read issue: only when the word cannot overflow the buffer once it lands.
    always_comb begin
        pop_s      = M_AXIS_TVALID & M_AXIS_TREADY;
        cap_s      = inflight_q;
        occ_s      = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop_s};
        FIFO_RD_EN = ~FIFO_EMPTY & ~ARESET & (occ_s <= 3'd1);
        inflight_d = FIFO_RD_EN;
    end

    // Buffer update: entry 0 is always the oldest word.
    always_comb begin
        buf0_d  = buf0_q;
        buf1_d  = buf1_q;
        count_d = count_q;
        case ({cap_s, pop_s})
            2'b01: begin
                buf0_d  = buf1_q;
                count_d = count_q - 2'd1;
            end
            2'b10: begin
                if (count_q == 2'd0) begin
                    buf0_d = new_entry_s;
                end else begin
                    buf1_d = new_entry_s;
                end
                count_d = count_q + 2'd1;
            end
            2'b11: begin
                if (count_q == 2'd1) begin
                    buf0_d = new_entry_s;
                end else begin
                    buf0_d = buf1_q;
                    buf1_d = new_entry_s;
                end
            end
            default: begin
                count_d = count_q;
            end
        endcase
    end

    // Buffer, occupancy and in-flight registers; reset drops everything pending.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            count_q    <= 2'd0;
            inflight_q <= 1'b0;
            buf0_q     <= {EW{1'b0}};
            buf1_q     <= {EW{1'b0}};
        end else begin
            count_q    <= count_d;
            inflight_q <= inflight_d;
            buf0_q     <= buf0_d;
            buf1_q     <= buf1_d;
        end
    end

endmodule

// File: tb/tb_fifo_axis_reader.sv
// Scoreboard bench for fifo_axis_reader: a behavioural upstream FIFO feeds the DUT, delivered words are popped against expectations.
module tb_fifo_axis_reader;
    localparam int DW = 16;
    localparam int FL = 4;

    logic          ACLK = 1'b0;
    logic          ARESET;
    logic          FIFO_RD_EN;
    logic [DW-1:0] FIFO_RD_DATA = '0;
    logic          FIFO_EMPTY;
    logic [DW-1:0] M_AXIS_TDATA;
    logic          M_AXIS_TVALID;
    logic          M_AXIS_TREADY;
    logic          M_AXIS_TLAST;

    fifo_axis_reader #(.DATA_WIDTH(DW), .FRAME_LEN(FL)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .FIFO_RD_EN(FIFO_RD_EN), .FIFO_RD_DATA(FIFO_RD_DATA), .FIFO_EMPTY(FIFO_EMPTY),
        .M_AXIS_TDATA(M_AXIS_TDATA), .M_AXIS_TVALID(M_AXIS_TVALID),
        .M_AXIS_TREADY(M_AXIS_TREADY), .M_AXIS_TLAST(M_AXIS_TLAST)
    );

    always #5 ACLK = ~ACLK;

    logic [DW-1:0] mem [0:1023];
    int wr_ptr = 0;
    int rd_ptr = 0;
    int rd_pulses = 0;
    int cyc = 0;
    assign FIFO_EMPTY = (wr_ptr == rd_ptr);

    // Upstream FIFO: registered read data, stale between reads.
    always @(posedge ACLK) begin
        cyc <= cyc + 1;
        if (FIFO_RD_EN && !FIFO_EMPTY) begin
            FIFO_RD_DATA <= mem[rd_ptr];
            rd_ptr       <= rd_ptr + 1;
        end
        if (FIFO_RD_EN) rd_pulses <= rd_pulses + 1;
    end

    logic [DW-1:0] exp_q [$];
    int exp_idx = 0;
    int total = 0;
    int bad = 0;
    int first_rd = -1, first_valid = -1, first_hs = -1, last_hs = -1;
    logic          stall_prev = 1'b0;
    logic [DW-1:0] stall_data = '0;
    logic          stall_last = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    task automatic put(input logic [DW-1:0] w);
        mem[wr_ptr] = w;
        wr_ptr      = wr_ptr + 1;
        exp_q.push_back(w);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge ACLK);
        #1;
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (exp_q.size() == 0) break;
            @(posedge ACLK);
        end
        chk("drain", exp_q.size(), 0);
        step(4);
        chk("idle_valid", M_AXIS_TVALID, 1'b0);
    endtask

    // Monitor: protocol checks and scoreboard pops, sampled mid-cycle.
    always @(negedge ACLK) begin
        logic [DW-1:0] w;
        logic          el;
        if (ARESET) begin
            stall_prev = 1'b0;
        end else begin
            chk("rd_while_empty", FIFO_RD_EN & FIFO_EMPTY, 1'b0);
            chk("count_max", dut.count_q == 2'd3, 1'b0);
            if (FIFO_RD_EN && first_rd < 0) first_rd = cyc;
            if (M_AXIS_TVALID && first_valid < 0) first_valid = cyc;
            if (stall_prev) begin
                chk("stall_valid", M_AXIS_TVALID, 1'b1);
                chk("stall_data", M_AXIS_TDATA, stall_data);
                chk("stall_last", M_AXIS_TLAST, stall_last);
            end
            if (M_AXIS_TVALID && M_AXIS_TREADY) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", M_AXIS_TDATA, 32'hFFFF_FFFF);
                end else begin
                    w = exp_q.pop_front();
`ifdef AXIS_TLAST_EN
                    el = (exp_idx == FL - 1);
`else
                    el = 1'b0;
`endif
                    exp_idx = (exp_idx == FL - 1) ? 0 : exp_idx + 1;
                    chk("tdata", M_AXIS_TDATA, w);
                    chk("tlast", M_AXIS_TLAST, el);
                    if (first_hs < 0) first_hs = cyc;
                    last_hs = cyc;
                end
            end
            stall_prev = M_AXIS_TVALID && !M_AXIS_TREADY;
            stall_data = M_AXIS_TDATA;
            stall_last = M_AXIS_TLAST;
        end
    end

    localparam logic [3:0] READY_PAT = 4'b1001;

    initial begin
        int base;
        int waited;
        ARESET        = 1'b1;
        M_AXIS_TREADY = 1'b0;
        step(3);
        chk("rst_valid", M_AXIS_TVALID, 1'b0);
        chk("rst_tdata", M_AXIS_TDATA, 16'h0000);
        chk("rst_tlast", M_AXIS_TLAST, 1'b0);
        chk("rst_rden", FIFO_RD_EN, 1'b0);

        // Idle with empty FIFO and ready downstream.
        ARESET        = 1'b0;
        M_AXIS_TREADY = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge ACLK);
            chk("idle_valid20", M_AXIS_TVALID, 1'b0);
            chk("idle_rden20", FIFO_RD_EN, 1'b0);
        end

        // Preloaded 1..8, streamed at full rate.
        step(1);
        ARESET  = 1'b1;
        exp_idx = 0;
        for (int i = 1; i <= 8; i++) put(16'(i));
        step(2);
        chk("rst_rden_nonempty", FIFO_RD_EN, 1'b0);
        first_rd = -1; first_valid = -1; first_hs = -1; last_hs = -1;
        base   = rd_pulses;
        ARESET = 1'b0;
        drain(100);
        chk("first_latency", first_valid - first_rd, 2);
        chk("consecutive", last_hs - first_hs, 7);
        chk("rd_pulses", rd_pulses - base, 8);

        // Backpressure pattern 1,0,0,1.
        for (int i = 0; i < 16; i++) put(16'h00A0 + 16'(i));
        for (int k = 0; k < 200; k++) begin
            if (exp_q.size() == 0) break;
            M_AXIS_TREADY = READY_PAT[3 - (k % 4)];
            step(1);
        end
        M_AXIS_TREADY = 1'b1;
        drain(50);

        // Ten words from a fresh frame.
        ARESET  = 1'b1;
        exp_idx = 0;
        step(2);
        ARESET = 1'b0;
        for (int i = 0; i < 10; i++) put(16'h0C00 + 16'(i));
        drain(100);
`ifdef AXIS_TLAST_EN
        chk("frame_cnt", dut.frame_cnt_q, 2);
`endif

        // Reset while a word is buffered and another is in flight.
        M_AXIS_TREADY = 1'b0;
        for (int i = 0; i < 6; i++) put(16'h00B0 + 16'(i));
        waited = 0;
        while (!(dut.count_q == 2'd1 && dut.inflight_q) && waited < 50) begin
            @(negedge ACLK);
            waited++;
        end
        chk("reach_inflight", waited < 50, 1'b1);
        ARESET = 1'b1;
        #1;
        chk("midrst_valid", M_AXIS_TVALID, 1'b0);
        chk("midrst_rden", FIFO_RD_EN, 1'b0);
        chk("midrst_tdata", M_AXIS_TDATA, 16'h0000);
        exp_q.delete();
        for (int p = rd_ptr; p < wr_ptr; p++) exp_q.push_back(mem[p]);
        exp_idx = 0;
        step(2);
        ARESET        = 1'b0;
        M_AXIS_TREADY = 1'b1;
        drain(100);

        // Long stream.
        for (int i = 0; i < 320; i++) put(16'h1000 + 16'(i));
        drain(1000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
